// File: rtl/set_arbiter_if.sv
// Requester-side bus of set_arbiter: per-requester request lanes plus the
// shared completion/response signals returned by the arbiter.
interface set_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int LINE_WIDTH = 32
);
    logic [N_REQ-1:0]            req;
    logic [N_REQ-1:0]            req_write;
    logic [N_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [N_REQ*LINE_WIDTH-1:0] req_wdata;
    logic [N_REQ-1:0]            done;
    logic [LINE_WIDTH-1:0]       rdata;
    logic                        resp_hit;
    logic                        resp_err;
    logic                        busy;

    // Requesters drive the request lanes and observe the responses.
    modport master (
        output req, req_write, req_addr, req_wdata,
        input  done, rdata, resp_hit, resp_err, busy
    );

    // The arbiter consumes the request lanes and produces the responses.
    modport slave (
        input  req, req_write, req_addr, req_wdata,
        output done, rdata, resp_hit, resp_err, busy
    );
endinterface

// File: rtl/set_arbiter.sv
// set_arbiter: round-robin front end that shares one K-way cache set between
// N_REQ requesters, sequences the set through its CLOCK-eviction write path and
// returns a one-cycle completion pulse with read data, hit and error status.
package set_arbiter_pkg;
    typedef enum logic [1:0] {
        E_NOTHING = 2'd0,
        E_PR_RD   = 2'd1,
        E_PR_WR   = 2'd2
    } bus_ev_t;

    typedef struct packed {
        bus_ev_t ev;
    } bus_prefix_t;
endpackage

module set_arbiter
    import set_arbiter_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int LINE_WIDTH = 32,
    parameter int K          = 2,
    parameter int TIMEOUT    = 2*K+2
)(
    input  logic                                   clock,
    input  logic                                   reset,
    set_arbiter_if.slave                           bus,
    output logic                                   set_enable,
    output logic                                   set_read,
    output logic                                   set_write,
    output logic [ADDR_WIDTH-1:0]                  set_addr,
    output logic [LINE_WIDTH-1:0]                  set_val,
    output logic [$bits(bus_prefix_t)+ADDR_WIDTH-1:0] set_bus,
    input  logic                                   set_hit,
    input  logic [LINE_WIDTH-1:0]                  set_out_val
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                state;
    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      grant_idx;
    logic [IDX_W-1:0]      pick;
    logic                  op_write;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic [WD_W-1:0]       watchdog;
    logic                  wd_expired;
    bus_prefix_t           prefix;
    logic [ADDR_WIDTH-1:0] bus_addr;

    logic [ADDR_WIDTH-1:0] addr_lane  [N_REQ];
    logic [LINE_WIDTH-1:0] wdata_lane [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_lane
        assign addr_lane[g]  = bus.req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_lane[g] = bus.req_wdata[g*LINE_WIDTH +: LINE_WIDTH];
    end

    // First requesting index at or after ptr, wrapping modulo N_REQ.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] sel;
        logic [IDX_W-1:0] cand;
        logic             found;
        sel   = ptr;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % N_REQ);
            if (!found && r[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(N_REQ-1)) ? '0 : idx + 1'b1;
    endfunction

    assign pick       = rr_pick(bus.req, rr_ptr);
    assign wd_expired = (watchdog == WD_W'(TIMEOUT-1));
    assign bus.busy   = (state != IDLE);
    assign set_bus    = {prefix, bus_addr};

    // Set controls: pulsed in ISSUE, held during a missing write sweep until hit or timeout.
    always_comb begin
        set_enable = 1'b0;
        set_read   = 1'b0;
        set_write  = 1'b0;
        set_addr   = '0;
        set_val    = '0;
        prefix.ev  = E_NOTHING;
        bus_addr   = '0;
        unique case (state)
            ISSUE: begin
                set_enable = 1'b1;
                set_read   = !op_write;
                set_write  = op_write;
                set_addr   = addr_q;
                set_val    = wdata_q;
                prefix.ev  = op_write ? E_PR_WR : E_PR_RD;
                bus_addr   = addr_q;
            end
            WAIT: begin
                // Keep the write asserted so the set advances its CLOCK pointer.
                if (op_write && !set_hit && !wd_expired) begin
                    set_enable = 1'b1;
                    set_write  = 1'b1;
                    set_addr   = addr_q;
                    set_val    = wdata_q;
                end
            end
            default: ;
        endcase
    end

    // Arbitration FSM with registered completion outputs (high only while in DONE).
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            watchdog     <= '0;
            bus.done     <= '0;
            bus.rdata    <= '0;
            bus.resp_hit <= 1'b0;
            bus.resp_err <= 1'b0;
        end else begin
            bus.done     <= '0;
            bus.rdata    <= '0;
            bus.resp_hit <= 1'b0;
            bus.resp_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|bus.req) begin
                        grant_idx <= pick;
                        op_write  <= bus.req_write[pick];
                        addr_q    <= addr_lane[pick];
                        wdata_q   <= wdata_lane[pick];
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    watchdog <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (!op_write) begin
                        bus.done     <= N_REQ'(1) << grant_idx;
                        bus.rdata    <= set_out_val;
                        bus.resp_hit <= set_hit;
                        state        <= DONE;
                    end else if (set_hit) begin
                        bus.done     <= N_REQ'(1) << grant_idx;
                        bus.resp_hit <= 1'b1;
                        state        <= DONE;
                    end else if (wd_expired) begin
                        bus.done     <= N_REQ'(1) << grant_idx;
                        bus.resp_err <= 1'b1;
                        state        <= DONE;
                    end else begin
                        watchdog <= watchdog + 1'b1;
                    end
                end
                DONE: begin
                    rr_ptr <= rr_next(grant_idx);
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_set_arbiter.sv
// Testbench for set_arbiter: a behavioural K-way CLOCK set model, a scoreboard
// of expected completions, and one task per scenario.
module tb_set_arbiter;
    import set_arbiter_pkg::*;

    localparam int N_REQ   = 4;
    localparam int AW      = 8;
    localparam int LW      = 32;
    localparam int K       = 2;
    localparam int TIMEOUT = 2*K+2;
    localparam int IW      = $clog2(N_REQ);
    localparam int PW      = $bits(bus_prefix_t);

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    set_arbiter_if #(.N_REQ(N_REQ), .ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus();

    logic           set_enable, set_read, set_write;
    logic [AW-1:0]  set_addr;
    logic [LW-1:0]  set_val;
    logic [PW+AW-1:0] set_bus;
    logic           set_hit;
    logic [LW-1:0]  set_out_val;

    set_arbiter #(.N_REQ(N_REQ), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .K(K), .TIMEOUT(TIMEOUT)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .set_enable  (set_enable),
        .set_read    (set_read),
        .set_write   (set_write),
        .set_addr    (set_addr),
        .set_val     (set_val),
        .set_bus     (set_bus),
        .set_hit     (set_hit),
        .set_out_val (set_out_val)
    );

    // Request lanes kept as arrays and packed onto the flattened bus.
    logic [AW-1:0] t_addr  [N_REQ];
    logic [LW-1:0] t_wdata [N_REQ];
    for (genvar g = 0; g < N_REQ; g++) begin : g_pack
        assign bus.req_addr[g*AW +: AW]  = t_addr[g];
        assign bus.req_wdata[g*LW +: LW] = t_wdata[g];
    end

    // ---------------- set model (CLOCK replacement) ----------------
    logic          model_clr, force_miss;
    logic          m_valid [K];
    logic [AW-1:0] m_tag   [K];
    logic [LW-1:0] m_data  [K];
    logic          m_cbit  [K];
    int            m_ptr;
    int            hit_idx;

    function automatic int find_line(input logic [AW-1:0] a);
        int r;
        r = -1;
        for (int k = 0; k < K; k++)
            if (m_valid[k] && m_tag[k] == a) r = k;
        return r;
    endfunction

    always_comb hit_idx = find_line(set_addr);

    always @(posedge clock) begin
        if (model_clr) begin
            for (int k = 0; k < K; k++) begin
                m_valid[k] <= 1'b0;
                m_cbit[k]  <= 1'b0;
                m_tag[k]   <= '0;
                m_data[k]  <= '0;
            end
            m_ptr       <= 0;
            set_hit     <= 1'b0;
            set_out_val <= '0;
        end else if (set_enable && set_read) begin
            if (hit_idx >= 0) begin
                set_hit         <= 1'b1;
                set_out_val     <= m_data[hit_idx];
                m_cbit[hit_idx] <= 1'b1;
            end else begin
                set_hit     <= 1'b0;
                set_out_val <= '0;
            end
        end else if (set_enable && set_write) begin
            if (force_miss) begin
                set_hit <= 1'b0;
            end else if (hit_idx >= 0) begin
                m_data[hit_idx] <= set_val;
                m_cbit[hit_idx] <= 1'b1;
                set_hit         <= 1'b1;
            end else if (!m_valid[m_ptr] || !m_cbit[m_ptr]) begin
                m_valid[m_ptr] <= 1'b1;
                m_tag[m_ptr]   <= set_addr;
                m_data[m_ptr]  <= set_val;
                m_cbit[m_ptr]  <= 1'b1;
                m_ptr          <= (m_ptr + 1) % K;
                set_hit        <= 1'b1;
            end else begin
                m_cbit[m_ptr] <= 1'b0;
                m_ptr         <= (m_ptr + 1) % K;
                set_hit       <= 1'b0;
            end
        end
    end

    // ---------------- scoreboard and observation ----------------
    typedef struct {
        logic [IW-1:0] idx;
        logic [LW-1:0] rdata;
        logic          hit;
        logic          err;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int checks   = 0;
    int failures = 0;

    int               cyc;
    int               wr_cycles;
    logic [N_REQ-1:0] obs_done;
    logic [LW-1:0]    obs_rdata;
    logic             obs_hit, obs_err;
    logic             n1_busy;
    logic [LW-1:0]    n1_rdata;
    logic [2:0]       n1_ctrl;
    logic [PW+AW-1:0] n1_bus;
    logic [2:0]       prev_ctrl, pre_done_ctrl;
    logic             wait_ev_bad;
    logic [PW+AW-1:0] exp_bus;

    task automatic drive_req(input logic [IW-1:0] idx, input logic wr,
                             input logic [AW-1:0] a, input logic [LW-1:0] d);
        bus.req[idx]       = 1'b1;
        bus.req_write[idx] = wr;
        t_addr[idx]        = a;
        t_wdata[idx]       = d;
    endtask

    // Watch negedges until a done pulse appears or the budget runs out (cyc = 0).
    task automatic wait_done(input int budget);
        logic [2:0] ctrl;
        cyc         = 0;
        wr_cycles   = 0;
        obs_done    = '0;
        wait_ev_bad = 1'b0;
        prev_ctrl   = 3'b000;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clock);
            ctrl = {set_enable, set_read, set_write};
            if (set_write) wr_cycles++;
            if (n == 1) begin
                n1_busy  = bus.busy;
                n1_rdata = bus.rdata;
                n1_ctrl  = ctrl;
                n1_bus   = set_bus;
            end else if (set_write && set_bus[PW+AW-1 -: PW] != E_NOTHING) begin
                wait_ev_bad = 1'b1;
            end
            if (bus.done != '0) begin
                cyc           = n;
                obs_done      = bus.done;
                obs_rdata     = bus.rdata;
                obs_hit       = bus.resp_hit;
                obs_err       = bus.resp_err;
                pre_done_ctrl = prev_ctrl;
                return;
            end
            prev_ctrl = ctrl;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        @(negedge clock);
        checks++; if (bus.done !== 4'b0000) begin failures++; $display("FAIL reset_done got=%b want=0000", bus.done); end
        checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h want=0", bus.rdata); end
        checks++; if ({bus.resp_hit, bus.resp_err} !== 2'b00) begin failures++; $display("FAIL reset_resp got=%b want=00", {bus.resp_hit, bus.resp_err}); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        checks++; if ({set_enable, set_read, set_write} !== 3'b000) begin failures++; $display("FAIL reset_set_ctrl got=%b want=000", {set_enable, set_read, set_write}); end
        checks++; if ({set_addr, set_val} !== '0) begin failures++; $display("FAIL reset_set_addr_val got=%h/%h want=0/0", set_addr, set_val); end
        checks++; if (set_bus !== '0) begin failures++; $display("FAIL reset_set_bus got=%h want=0", set_bus); end
        reset = 1'b0;
        @(negedge clock);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b want=0", bus.busy); end
    endtask

    // Requester 3 fills both lines: 0x10 -> DEADBEEF, 0x30 -> 0x55.
    task automatic test_fill();
        logic [AW-1:0] a [2];
        logic [LW-1:0] d [2];
        a[0] = 8'h10; d[0] = 32'hDEADBEEF;
        a[1] = 8'h30; d[1] = 32'h00000055;
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{idx: 2'd3, rdata: '0, hit: 1'b1, err: 1'b0});
            drive_req(2'd3, 1'b1, a[i], d[i]);
            wait_done(12);
            bus.req[3] = 1'b0;
            e = sb.pop_front();
            checks++; if (cyc !== 3) begin failures++; $display("FAIL fill_latency[%0d] got=%0d want=3", i, cyc); end
            checks++; if (obs_done !== (N_REQ'(1) << e.idx) || obs_hit !== e.hit || obs_err !== e.err) begin
                failures++; $display("FAIL fill_resp[%0d] got done=%b hit=%b err=%b want done=%b hit=%b err=%b",
                                     i, obs_done, obs_hit, obs_err, N_REQ'(1) << e.idx, e.hit, e.err); end
            @(negedge clock);
        end
    endtask

    task automatic test_read_latency();
        sb.push_back('{idx: 2'd0, rdata: 32'hDEADBEEF, hit: 1'b1, err: 1'b0});
        drive_req(2'd0, 1'b0, 8'h10, '0);
        wait_done(12);
        bus.req[0] = 1'b0;
        e = sb.pop_front();
        exp_bus = {E_PR_RD, 8'h10};
        checks++; if (cyc !== 3) begin failures++; $display("FAIL read_latency got=%0d want=3", cyc); end
        checks++; if (n1_busy !== 1'b1) begin failures++; $display("FAIL read_busy got=%b want=1", n1_busy); end
        checks++; if (n1_rdata !== 32'h0) begin failures++; $display("FAIL read_rdata_outside_done got=%h want=0", n1_rdata); end
        checks++; if (n1_ctrl !== 3'b110) begin failures++; $display("FAIL read_issue_ctrl got=%b want=110", n1_ctrl); end
        checks++; if (n1_bus !== exp_bus) begin failures++; $display("FAIL read_issue_bus got=%h want=%h", n1_bus, exp_bus); end
        checks++; if (obs_done !== (N_REQ'(1) << e.idx)) begin failures++; $display("FAIL read_done got=%b want=%b", obs_done, N_REQ'(1) << e.idx); end
        checks++; if (obs_rdata !== e.rdata || obs_hit !== e.hit) begin
            failures++; $display("FAIL read_data got=%h hit=%b want=%h hit=%b", obs_rdata, obs_hit, e.rdata, e.hit); end
        @(negedge clock);
    endtask

    // Write of a new address into a full set with all clock bits set: two sweeps then replace.
    task automatic test_sweep_write();
        sb.push_back('{idx: 2'd3, rdata: '0, hit: 1'b1, err: 1'b0});
        drive_req(2'd3, 1'b1, 8'h20, 32'h00001234);
        wait_done(16);
        bus.req[3] = 1'b0;
        e = sb.pop_front();
        exp_bus = {E_PR_WR, 8'h20};
        checks++; if (n1_ctrl !== 3'b101 || n1_bus !== exp_bus) begin
            failures++; $display("FAIL sweep_issue got ctrl=%b bus=%h want ctrl=101 bus=%h", n1_ctrl, n1_bus, exp_bus); end
        checks++; if (wr_cycles !== K+1) begin failures++; $display("FAIL sweep_write_cycles got=%0d want=%0d", wr_cycles, K+1); end
        checks++; if (wait_ev_bad !== 1'b0) begin failures++; $display("FAIL sweep_bus_event got=%b want=0", wait_ev_bad); end
        checks++; if (cyc !== K+3) begin failures++; $display("FAIL sweep_latency got=%0d want=%0d", cyc, K+3); end
        checks++; if (obs_done !== (N_REQ'(1) << e.idx) || obs_hit !== e.hit || obs_err !== e.err || obs_rdata !== e.rdata) begin
            failures++; $display("FAIL sweep_resp got done=%b hit=%b err=%b rdata=%h want done=%b hit=1 err=0 rdata=0",
                                 obs_done, obs_hit, obs_err, obs_rdata, N_REQ'(1) << e.idx); end
        @(negedge clock);
        sb.push_back('{idx: 2'd3, rdata: 32'h00001234, hit: 1'b1, err: 1'b0});
        drive_req(2'd3, 1'b0, 8'h20, '0);
        wait_done(12);
        bus.req[3] = 1'b0;
        e = sb.pop_front();
        checks++; if (obs_rdata !== e.rdata || obs_hit !== e.hit || cyc !== 3) begin
            failures++; $display("FAIL sweep_readback got rdata=%h hit=%b cyc=%0d want rdata=%h hit=1 cyc=3", obs_rdata, obs_hit, cyc, e.rdata); end
        @(negedge clock);
    endtask

    task automatic test_write_hit();
        sb.push_back('{idx: 2'd3, rdata: '0, hit: 1'b1, err: 1'b0});
        drive_req(2'd3, 1'b1, 8'h30, 32'h00000077);
        wait_done(12);
        bus.req[3] = 1'b0;
        e = sb.pop_front();
        checks++; if (cyc !== 3) begin failures++; $display("FAIL whit_latency got=%0d want=3", cyc); end
        checks++; if (wr_cycles < 1 || wr_cycles > 2) begin failures++; $display("FAIL whit_write_cycles got=%0d want=1..2", wr_cycles); end
        checks++; if (pre_done_ctrl !== 3'b000) begin failures++; $display("FAIL whit_ctrl_drop got=%b want=000", pre_done_ctrl); end
        checks++; if (obs_hit !== e.hit || obs_err !== e.err) begin
            failures++; $display("FAIL whit_resp got hit=%b err=%b want hit=1 err=0", obs_hit, obs_err); end
        @(negedge clock);
    endtask

    // All four request reads together; requester 0 re-requests and is served last.
    task automatic test_round_robin();
        sb.push_back('{idx: 2'd0, rdata: 32'h00000077, hit: 1'b1, err: 1'b0});
        sb.push_back('{idx: 2'd1, rdata: 32'h00001234, hit: 1'b1, err: 1'b0});
        sb.push_back('{idx: 2'd2, rdata: 32'h0,        hit: 1'b0, err: 1'b0});
        sb.push_back('{idx: 2'd3, rdata: 32'h0,        hit: 1'b0, err: 1'b0});
        sb.push_back('{idx: 2'd0, rdata: 32'h00000077, hit: 1'b1, err: 1'b0});
        drive_req(2'd0, 1'b0, 8'h30, '0);
        drive_req(2'd1, 1'b0, 8'h20, '0);
        drive_req(2'd2, 1'b0, 8'h10, '0);
        drive_req(2'd3, 1'b0, 8'h40, '0);
        for (int i = 0; i < 5; i++) begin
            wait_done(12);
            e = sb.pop_front();
            checks++; if (obs_done !== (N_REQ'(1) << e.idx)) begin
                failures++; $display("FAIL rr_order[%0d] got=%b want=%b", i, obs_done, N_REQ'(1) << e.idx); end
            checks++; if (obs_rdata !== e.rdata || obs_hit !== e.hit) begin
                failures++; $display("FAIL rr_data[%0d] got=%h hit=%b want=%h hit=%b", i, obs_rdata, obs_hit, e.rdata, e.hit); end
            checks++; if (cyc !== ((i == 0) ? 3 : 4)) begin
                failures++; $display("FAIL rr_spacing[%0d] got=%0d want=%0d", i, cyc, (i == 0) ? 3 : 4); end
        end
        bus.req = '0;
        @(negedge clock);
    endtask

    task automatic test_timeout();
        force_miss = 1'b1;
        sb.push_back('{idx: 2'd1, rdata: '0, hit: 1'b0, err: 1'b1});
        drive_req(2'd1, 1'b1, 8'h60, 32'h0000ABCD);
        wait_done(TIMEOUT + 10);
        bus.req[1] = 1'b0;
        force_miss = 1'b0;
        e = sb.pop_front();
        checks++; if (cyc !== TIMEOUT+2) begin failures++; $display("FAIL to_latency got=%0d want=%0d", cyc, TIMEOUT+2); end
        checks++; if (wr_cycles !== TIMEOUT) begin failures++; $display("FAIL to_write_cycles got=%0d want=%0d", wr_cycles, TIMEOUT); end
        checks++; if (pre_done_ctrl !== 3'b000) begin failures++; $display("FAIL to_ctrl_drop got=%b want=000", pre_done_ctrl); end
        checks++; if (obs_done !== (N_REQ'(1) << e.idx) || obs_hit !== e.hit || obs_err !== e.err || obs_rdata !== e.rdata) begin
            failures++; $display("FAIL to_resp got done=%b hit=%b err=%b rdata=%h want done=%b hit=0 err=1 rdata=0",
                                 obs_done, obs_hit, obs_err, obs_rdata, N_REQ'(1) << e.idx); end
        @(negedge clock);
    endtask

    // Reset in the middle of a stalled write; round-robin pointer restarts at 0.
    task automatic test_reset_mid_write();
        force_miss = 1'b1;
        drive_req(2'd2, 1'b1, 8'h50, 32'h00000099);
        repeat (3) @(negedge clock);
        checks++; if (bus.busy !== 1'b1 || set_write !== 1'b1) begin
            failures++; $display("FAIL rst_pre_busy got busy=%b set_write=%b want 1/1", bus.busy, set_write); end
        reset = 1'b1;
        @(negedge clock);
        checks++; if (bus.busy !== 1'b0 || bus.done !== 4'b0000 || set_write !== 1'b0) begin
            failures++; $display("FAIL rst_abandon got busy=%b done=%b set_write=%b want 0/0000/0", bus.busy, bus.done, set_write); end
        reset      = 1'b0;
        force_miss = 1'b0;
        sb.push_back('{idx: 2'd0, rdata: 32'h00000077, hit: 1'b1, err: 1'b0});
        sb.push_back('{idx: 2'd2, rdata: '0,           hit: 1'b1, err: 1'b0});
        drive_req(2'd0, 1'b0, 8'h30, '0);
        for (int i = 0; i < 2; i++) begin
            wait_done(16);
            e = sb.pop_front();
            bus.req[e.idx] = 1'b0;
            checks++; if (obs_done !== (N_REQ'(1) << e.idx)) begin
                failures++; $display("FAIL rst_priority[%0d] got=%b want=%b", i, obs_done, N_REQ'(1) << e.idx); end
            checks++; if (obs_rdata !== e.rdata || obs_hit !== e.hit || obs_err !== e.err) begin
                failures++; $display("FAIL rst_resp[%0d] got=%h hit=%b err=%b want=%h hit=%b err=%b",
                                     i, obs_rdata, obs_hit, obs_err, e.rdata, e.hit, e.err); end
        end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL sb_drain got=%0d want=0", sb.size()); end
        @(negedge clock);
    endtask

    initial begin
        reset         = 1'b1;
        model_clr     = 1'b1;
        force_miss    = 1'b0;
        bus.req       = '0;
        bus.req_write = '0;
        for (int i = 0; i < N_REQ; i++) begin
            t_addr[i]  = '0;
            t_wdata[i] = '0;
        end
        repeat (3) @(negedge clock);
        model_clr = 1'b0;
        test_reset();
        test_fill();
        test_read_latency();
        test_sweep_write();
        test_write_hit();
        test_round_robin();
        test_timeout();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
